route_comp_torus: RTL and testbench

ROUTE_COMP_TORUS -- requirements
Module: route_comp_torus

---
 rtl/route_comp_torus.sv | 239 +++++++++++++++++++++++
 tb/tb_route_comp_torus.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/route_comp_torus.sv
// route_comp_torus: route computation stage for a 3-D torus router.
// Accepts flits from upstream, picks an output direction for each packet
// (minimal torus routing, dimension order XYZ or ZYX), and presents the
// flit unmodified with its direction on a registered output. Body flits
// follow the direction latched from their head (wormhole). Buffering is
// one output register plus one skid register.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - upstream handshake (in_ready is registered)
//   in_flit             - upstream flit, FLIT_W bits
//   out_valid/out_ready - downstream handshake
//   out_flit            - accepted flit, unmodified
//   out_dir             - 0 INJECT, 1 XPOS, 2 YPOS, 3 ZPOS, 4 XNEG, 5 YNEG, 6 ZNEG, 7 EJECT
//   out_eject           - out_valid && out_dir == EJECT
//   err                 - one-cycle pulse on a dropped flit or a head inside a packet
//   pkt_cnt             - saturating count of routed heads
module route_comp_torus #(
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0,
  parameter int CUR_Z      = 0,
  parameter int XSIZE      = 4,
  parameter int YSIZE      = 4,
  parameter int ZSIZE      = 4,
  parameter int COORD_W    = 3,
  parameter int FLIT_W     = 85,
  parameter int DST_POS    = 72,
  parameter int HEAD_POS   = 83,
  parameter int TAIL_POS   = 84,
  parameter int ROUTE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              out_ready,
  output logic [2:0]        out_dir,
  output logic              out_eject,
  output logic              err,
  output logic [15:0]       pkt_cnt
);

  // One extra bit so a size of 1<<COORD_W and the modular sum never overflow.
  typedef logic [COORD_W:0] crd_t;

  localparam crd_t CX = crd_t'(CUR_X);
  localparam crd_t CY = crd_t'(CUR_Y);
  localparam crd_t CZ = crd_t'(CUR_Z);
  localparam crd_t SX = crd_t'(XSIZE);
  localparam crd_t SY = crd_t'(YSIZE);
  localparam crd_t SZ = crd_t'(ZSIZE);

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_XPOS  = 3'd1;
  localparam logic [2:0] DIR_YPOS  = 3'd2;
  localparam logic [2:0] DIR_ZPOS  = 3'd3;
  localparam logic [2:0] DIR_XNEG  = 3'd4;
  localparam logic [2:0] DIR_YNEG  = 3'd5;
  localparam logic [2:0] DIR_ZNEG  = 3'd6;
  localparam logic [2:0] DIR_EJECT = 3'd7;

  typedef enum logic [0:0] {IDLE = 1'b0, PKT = 1'b1} state_t;

  // Direction for one dimension; DIR_NONE when already aligned.
  // delta = (dst - cur) mod size, with dst and cur both below size.
  function automatic logic [2:0] dim_dir(input crd_t dst, input crd_t cur, input crd_t size,
                                         input logic [2:0] pos, input logic [2:0] neg);
    crd_t delta;
    if (dst >= cur) begin
      delta = dst - cur;
    end else begin
      delta = (size - cur) + dst;
    end
    if (delta == {(COORD_W+1){1'b0}}) begin
      dim_dir = DIR_NONE;
    end else if (delta <= (size >> 1)) begin
      dim_dir = pos;
    end else begin
      dim_dir = neg;
    end
  endfunction

  state_t              state_r;
  logic [2:0]          lat_dir_r;
  logic [15:0]         pkt_cnt_r;
  logic                err_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [FLIT_W-1:0]   out_flit_r;
  logic [2:0]          out_dir_r;
  logic                out_eject_r;
  logic                skid_valid_r;
  logic [FLIT_W-1:0]   skid_flit_r;
  logic [2:0]          skid_dir_r;

  crd_t                dst_x_s, dst_y_s, dst_z_s;
  logic [2:0]          dx_s, dy_s, dz_s, first_s, last_s, route_dir_s, fwd_dir_s;
  logic                is_head_s, is_tail_s, dst_bad_s, accept_s, drop_s, fwd_s, err_ev_s;
  logic                out_load_s, out_valid_n, skid_valid_n;
  logic [FLIT_W-1:0]   out_flit_n, skid_flit_n;
  logic [2:0]          out_dir_n, skid_dir_n;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_flit  = out_flit_r;
  assign out_dir   = out_dir_r;
  assign out_eject = out_eject_r;
  assign err       = err_r;
  assign pkt_cnt   = pkt_cnt_r;

  // Route decode of the incoming flit and accept/drop classification.
  always_comb begin
    dst_x_s   = {1'b0, in_flit[DST_POS +: COORD_W]};
    dst_y_s   = {1'b0, in_flit[DST_POS + COORD_W +: COORD_W]};
    dst_z_s   = {1'b0, in_flit[DST_POS + 2*COORD_W +: COORD_W]};
    is_head_s = in_flit[HEAD_POS];
    is_tail_s = in_flit[TAIL_POS];
    dst_bad_s = (dst_x_s >= SX) || (dst_y_s >= SY) || (dst_z_s >= SZ);
    dx_s      = dim_dir(dst_x_s, CX, SX, DIR_XPOS, DIR_XNEG);
    dy_s      = dim_dir(dst_y_s, CY, SY, DIR_YPOS, DIR_YNEG);
    dz_s      = dim_dir(dst_z_s, CZ, SZ, DIR_ZPOS, DIR_ZNEG);
    first_s   = (ROUTE_MODE == 0) ? dx_s : dz_s;
    last_s    = (ROUTE_MODE == 0) ? dz_s : dx_s;
    if (first_s != DIR_NONE) begin
      route_dir_s = first_s;
    end else if (dy_s != DIR_NONE) begin
      route_dir_s = dy_s;
    end else if (last_s != DIR_NONE) begin
      route_dir_s = last_s;
    end else begin
      route_dir_s = DIR_EJECT;
    end
    accept_s  = in_valid && in_ready_r;
    // Heads stand or fall on their destination; non-heads are only legal inside a packet.
    drop_s    = is_head_s ? dst_bad_s : (state_r == IDLE);
    fwd_s     = accept_s && !drop_s;
    fwd_dir_s = is_head_s ? route_dir_s : lat_dir_r;
    err_ev_s  = accept_s && (drop_s || (is_head_s && (state_r == PKT)));
  end

  // Next-state of the output register and skid register.
  always_comb begin
    out_load_s   = !out_valid_r || out_ready;
    out_valid_n  = out_valid_r;
    out_flit_n   = out_flit_r;
    out_dir_n    = out_dir_r;
    skid_valid_n = skid_valid_r;
    skid_flit_n  = skid_flit_r;
    skid_dir_n   = skid_dir_r;
    if (out_load_s) begin
      // The skid holds the older flit; in_ready was low while it was full.
      if (skid_valid_r) begin
        out_valid_n  = 1'b1;
        out_flit_n   = skid_flit_r;
        out_dir_n    = skid_dir_r;
        skid_valid_n = 1'b0;
      end else if (fwd_s) begin
        out_valid_n = 1'b1;
        out_flit_n  = in_flit;
        out_dir_n   = fwd_dir_s;
      end else begin
        out_valid_n = 1'b0;
      end
    end else begin
      if (fwd_s) begin
        skid_valid_n = 1'b1;
        skid_flit_n  = in_flit;
        skid_dir_n   = fwd_dir_s;
      end else begin
        skid_valid_n = skid_valid_r;
      end
    end
  end

  // Output/skid registers and the registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_flit_r   <= {FLIT_W{1'b0}};
      out_dir_r    <= 3'd0;
      out_eject_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_flit_r  <= {FLIT_W{1'b0}};
      skid_dir_r   <= 3'd0;
    end else begin
      in_ready_r   <= !skid_valid_n;
      out_valid_r  <= out_valid_n;
      out_flit_r   <= out_flit_n;
      out_dir_r    <= out_dir_n;
      out_eject_r  <= out_valid_n && (out_dir_n == DIR_EJECT);
      skid_valid_r <= skid_valid_n;
      skid_flit_r  <= skid_flit_n;
      skid_dir_r   <= skid_dir_n;
    end
  end

  // Packet FSM: latched route, head counter and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      lat_dir_r <= 3'd0;
      pkt_cnt_r <= 16'd0;
      err_r     <= 1'b0;
    end else begin
      err_r <= err_ev_s;
      if (accept_s) begin
        case (state_r)
          IDLE, PKT: begin
            if (is_head_s) begin
              if (dst_bad_s) begin
                state_r <= IDLE;
              end else begin
                lat_dir_r <= route_dir_s;
                if (pkt_cnt_r != 16'hFFFF) begin
                  pkt_cnt_r <= pkt_cnt_r + 16'd1;
                end else begin
                  pkt_cnt_r <= pkt_cnt_r;
                end
                state_r <= is_tail_s ? IDLE : PKT;
              end
            end else if ((state_r == PKT) && is_tail_s) begin
              state_r <= IDLE;
            end else begin
              state_r <= state_r;
            end
          end
          default: state_r <= IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_route_comp_torus.sv
// Directed bench for route_comp_torus. Three instances share one stimulus:
//   a_*: cur=(1,2,3), sizes 4, XYZ order
//   b_*: cur=(1,2,3), sizes 4, ZYX order
//   c_*: cur=(0,0,0), XSIZE=5, XYZ order
module tb_route_comp_torus;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [84:0] in_flit;
  logic        out_ready;

  logic a_in_ready, a_out_valid, a_out_eject, a_err;
  logic b_in_ready, b_out_valid, b_out_eject, b_err;
  logic c_in_ready, c_out_valid, c_out_eject, c_err;
  logic [84:0] a_out_flit, b_out_flit, c_out_flit;
  logic [2:0]  a_out_dir, b_out_dir, c_out_dir;
  logic [15:0] a_pkt_cnt, b_pkt_cnt, c_pkt_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  route_comp_torus #(.CUR_X(1), .CUR_Y(2), .CUR_Z(3), .ROUTE_MODE(0)) u_xyz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_flit(a_out_flit), .out_ready(out_ready), .out_dir(a_out_dir),
    .out_eject(a_out_eject), .err(a_err), .pkt_cnt(a_pkt_cnt));

  route_comp_torus #(.CUR_X(1), .CUR_Y(2), .CUR_Z(3), .ROUTE_MODE(1)) u_zyx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_flit(b_out_flit), .out_ready(out_ready), .out_dir(b_out_dir),
    .out_eject(b_out_eject), .err(b_err), .pkt_cnt(b_pkt_cnt));

  route_comp_torus #(.CUR_X(0), .CUR_Y(0), .CUR_Z(0), .XSIZE(5), .ROUTE_MODE(0)) u_x5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_flit(c_out_flit), .out_ready(out_ready), .out_dir(c_out_dir),
    .out_eject(c_out_eject), .err(c_err), .pkt_cnt(c_pkt_cnt));

  function automatic logic [84:0] mk(input logic hd, input logic tl, input logic [2:0] x,
                                     input logic [2:0] y, input logic [2:0] z, input logic [15:0] pl);
    logic [84:0] f;
    f = 85'd0;
    f[84] = tl;
    f[83] = hd;
    f[74:72] = x;
    f[77:75] = y;
    f[80:78] = z;
    f[15:0] = pl;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [84:0] obs, input logic [84:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one flit for one cycle; returns at the next negedge with in_valid low.
  task automatic send1(input logic [84:0] f);
    in_valid = 1'b1;
    in_flit  = f;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [84:0] f, h, p [0:5];
  logic        acc;
  int          idx, nacc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = 85'd0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 85'd0);
    chk("rst_out_valid", a_out_valid, 85'd0);
    chk("rst_out_dir", a_out_dir, 85'd0);
    chk("rst_out_flit", a_out_flit, 85'd0);
    chk("rst_err", a_err, 85'd0);
    chk("rst_pkt_cnt", a_pkt_cnt, 85'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 85'd1);

    // Single-flit packets from (1,2,3): XPOS, XNEG, EJECT.
    f = mk(1'b1, 1'b1, 3'd3, 3'd2, 3'd3, 16'h0001);
    send1(f);
    chk("sf1_valid", a_out_valid, 85'd1);
    chk("sf1_flit", a_out_flit, f);
    chk("sf1_dir", a_out_dir, 85'd1);
    chk("sf1_eject", a_out_eject, 85'd0);
    chk("sf1_zyx_dir", b_out_dir, 85'd1);
    f = mk(1'b1, 1'b1, 3'd0, 3'd2, 3'd3, 16'h0002);
    send1(f);
    chk("sf2_dir", a_out_dir, 85'd4);
    chk("sf2_eject", a_out_eject, 85'd0);
    f = mk(1'b1, 1'b1, 3'd1, 3'd2, 3'd3, 16'h0003);
    send1(f);
    chk("sf3_dir", a_out_dir, 85'd7);
    chk("sf3_eject", a_out_eject, 85'd1);
    chk("sf3_pkt_cnt", a_pkt_cnt, 85'd3);

    // Dimension order: Z first in ZYX mode, X first in XYZ mode.
    f = mk(1'b1, 1'b1, 3'd2, 3'd0, 3'd0, 16'h0004);
    send1(f);
    chk("zyx_dir", b_out_dir, 85'd3);
    chk("xyz_dir", a_out_dir, 85'd1);

    // Non-power-of-2 extent XSIZE=5 from x=0.
    f = mk(1'b1, 1'b1, 3'd3, 3'd0, 3'd0, 16'h0005);
    send1(f);
    chk("x5_d3_dir", c_out_dir, 85'd4);
    f = mk(1'b1, 1'b1, 3'd2, 3'd0, 3'd0, 16'h0006);
    send1(f);
    chk("x5_d2_dir", c_out_dir, 85'd1);
    chk("x5_cnt_before_bad", c_pkt_cnt, 85'd6);
    f = mk(1'b1, 1'b1, 3'd5, 3'd0, 3'd0, 16'h0007);
    send1(f);
    chk("x5_bad_err", c_err, 85'd1);
    chk("x5_bad_valid", c_out_valid, 85'd0);
    chk("x5_bad_cnt", c_pkt_cnt, 85'd6);
    chk("xyz_bad_cnt", a_pkt_cnt, 85'd6);
    @(negedge clk);
    chk("x5_err_pulse_end", c_err, 85'd0);

    // Wormhole: head, two bodies whose dst would eject, tail; all follow the head.
    in_valid = 1'b1;
    in_flit = mk(1'b1, 1'b0, 3'd3, 3'd2, 3'd3, 16'h0010);
    @(negedge clk);
    chk("wh_head_dir", a_out_dir, 85'd1);
    in_flit = mk(1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0011);
    @(negedge clk);
    chk("wh_body1_dir", a_out_dir, 85'd1);
    chk("wh_body1_flit", a_out_flit, mk(1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0011));
    in_flit = mk(1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0012);
    @(negedge clk);
    chk("wh_body2_dir", a_out_dir, 85'd1);
    in_flit = mk(1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 16'h0013);
    @(negedge clk);
    chk("wh_tail_dir", a_out_dir, 85'd1);
    chk("wh_tail_valid", a_out_valid, 85'd1);
    chk("wh_pkt_cnt", a_pkt_cnt, 85'd7);
    // A stray body after the tail proves the FSM is back in IDLE.
    in_flit = mk(1'b0, 1'b0, 3'd3, 3'd2, 3'd3, 16'h0014);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stray_err", a_err, 85'd1);
    chk("stray_valid", a_out_valid, 85'd0);

    // Head arriving inside a packet restarts the route and flags err.
    send1(mk(1'b1, 1'b0, 3'd0, 3'd2, 3'd3, 16'h0020));
    chk("pkt_head_dir", a_out_dir, 85'd4);
    chk("pkt_head_err0", a_err, 85'd0);
    send1(mk(1'b1, 1'b1, 3'd3, 3'd2, 3'd3, 16'h0021));
    chk("rehead_dir", a_out_dir, 85'd1);
    chk("rehead_err", a_err, 85'd1);
    chk("rehead_cnt", a_pkt_cnt, 85'd9);
    @(negedge clk);

    // Backpressure: 4 stalled cycles accept exactly two flits, then drain in order.
    for (int i = 0; i < 6; i++) p[i] = mk(1'b1, 1'b1, 3'd3, 3'd2, 3'd3, 16'h0100 + 16'(i));
    idx = 0; nacc = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_flit = p[0];
    for (int c = 0; c < 4; c++) begin
      acc = a_in_ready;
      @(negedge clk);
      if (acc) begin nacc++; idx++; in_flit = p[idx]; end
      chk("bp_hold_flit", a_out_flit, p[0]);
      chk("bp_hold_valid", a_out_valid, 85'd1);
    end
    chk("bp_accepted", 85'(nacc), 85'd2);
    chk("bp_in_ready", a_in_ready, 85'd0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      acc = a_in_ready;
      @(negedge clk);
      if (acc) begin idx++; in_flit = p[idx]; end
      chk("drain_flit", a_out_flit, p[k]);
      chk("drain_valid", a_out_valid, 85'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_empty", a_out_valid, 85'd0);

    // Reset in the middle of a packet discards the route.
    h = mk(1'b1, 1'b0, 3'd3, 3'd2, 3'd3, 16'h0200);
    send1(h);
    chk("mid_head_dir", a_out_dir, 85'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", a_out_valid, 85'd0);
    chk("mid_rst_in_ready", a_in_ready, 85'd0);
    chk("mid_rst_cnt", a_pkt_cnt, 85'd0);
    @(negedge clk);
    chk("mid_rst_ready_back", a_in_ready, 85'd1);
    send1(mk(1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0201));
    chk("after_rst_body_err", a_err, 85'd1);
    chk("after_rst_body_valid", a_out_valid, 85'd0);
    @(negedge clk);
    chk("after_rst_still_empty", a_out_valid, 85'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
